// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, runtime-selectable baud and parity.
// Reports data, parity error and framing error with a one-clock valid pulse.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       active
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [31:0] DIV_2400  = 32'(CLK_FREQ / 38400);
    localparam logic [31:0] DIV_4800  = 32'(CLK_FREQ / 76800);
    localparam logic [31:0] DIV_9600  = 32'(CLK_FREQ / 153600);
    localparam logic [31:0] DIV_19200 = 32'(CLK_FREQ / 307200);

    logic        rx_s1, rx_s2, rx_prev;
    logic [2:0]  state;
    logic [1:0]  baud_lat, par_lat;
    logic [31:0] tick_cnt, div_sel;
    logic [3:0]  samp_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        par_bad, stop_bad, done;
    logic        tick, fall, par_en, start_now;

    always_comb begin
        div_sel = DIV_2400;
        case (baud_lat)
            2'b00:   div_sel = DIV_2400;
            2'b01:   div_sel = DIV_4800;
            2'b10:   div_sel = DIV_9600;
            default: div_sel = DIV_19200;
        endcase
    end

    assign tick   = (tick_cnt == div_sel - 32'd1);
    assign fall   = rx_prev & ~rx_s2;
    assign par_en = par_lat[0] ^ par_lat[1];
    assign active = (state != IDLE);
    // The completion cycle doubles as an IDLE cycle so back-to-back frames are caught
    assign start_now = fall && ((state == IDLE) || (state == STOP && done));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= IDLE;
            baud_lat   <= '0;
            par_lat    <= '0;
            tick_cnt   <= '0;
            samp_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            valid   <= 1'b0;

            if (state != IDLE)
                tick_cnt <= tick ? '0 : tick_cnt + 32'd1;

            case (state)
                START: if (tick) begin
                    if (samp_cnt == 4'd7) begin
                        samp_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s2 ? IDLE : DATA;
                    end else begin
                        samp_cnt <= samp_cnt + 4'd1;
                    end
                end
                DATA: if (tick) begin
                    samp_cnt <= samp_cnt + 4'd1;
                    if (samp_cnt == 4'd15) begin
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= par_en ? PARITY : STOP;
                    end
                end
                PARITY: if (tick) begin
                    samp_cnt <= samp_cnt + 4'd1;
                    if (samp_cnt == 4'd15) begin
                        par_bad <= rx_s2 ^ (^shift) ^ par_lat[0];
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (done) begin
                        data_out   <= shift;
                        parity_err <= par_bad;
                        frame_err  <= stop_bad;
                        valid      <= 1'b1;
                        done       <= 1'b0;
                        state      <= IDLE;
                    end else if (tick) begin
                        samp_cnt <= samp_cnt + 4'd1;
                        if (samp_cnt == 4'd15) begin
                            stop_bad <= ~rx_s2;
                            done     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (start_now) begin
                state    <= START;
                tick_cnt <= '0;
                samp_cnt <= '0;
                baud_lat <= baud_rate;
                par_lat  <= parity_type;
                par_bad  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are pushed to a scoreboard as they are
// driven and checked by a monitor when valid pulses.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 614400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [1:0] baud_rate = 2'b10;
    logic [1:0] parity_type = 2'b00;
    logic [7:0] data_out;
    logic       valid, parity_err, frame_err, active;

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    logic prev_v = 1'b0;
    logic [9:0] sb[$];

    uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk), .rst(rst), .rx(rx), .baud_rate(baud_rate),
        .parity_type(parity_type), .data_out(data_out), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .active(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bit_clks(input logic [1:0] br);
        int rate;
        case (br)
            2'b00:   rate = 2400;
            2'b01:   rate = 4800;
            2'b10:   rate = 9600;
            default: rate = 19200;
        endcase
        return 16 * (CLK_FREQ / (rate * 16));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                logic [9:0] e;
                n_valid++;
                chk("valid_width", {31'd0, prev_v}, 32'd0);
                n_assert++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_valid: observed data %0h expected no frame", data_out);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("data_out",   {24'd0, data_out},   {24'd0, e[9:2]});
                    chk("parity_err", {31'd0, parity_err}, {31'd0, e[1]});
                    chk("frame_err",  {31'd0, frame_err},  {31'd0, e[0]});
                end
            end
            prev_v = valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic [1:0] br, input logic [1:0] pt,
                              input logic par_bit, input logic stop_bit,
                              input logic [1:0] mid_br, input logic [1:0] mid_pt);
        int   bc;
        logic has_par, good_par;
        bc       = bit_clks(br);
        has_par  = (pt == 2'b01) || (pt == 2'b10);
        good_par = (pt == 2'b01) ? ~(^d) : (^d);
        sb.push_back({d, has_par && (par_bit !== good_par), ~stop_bit});
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        baud_rate   = mid_br;
        parity_type = mid_pt;
        chk("active_in_frame", {31'd0, active}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bc) @(negedge clk);
        end
        if (has_par) begin
            rx = par_bit;
            repeat (bc) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bc) @(negedge clk);
    endtask

    task automatic wait_valid(input int exp_cnt);
        for (int i = 0; i < 4000 && n_valid < exp_cnt; i++) @(negedge clk);
        chk("valid_count", n_valid, exp_cnt);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_valid",    {31'd0, valid},    32'd0);
        chk("rst_perr",     {31'd0, parity_err}, 32'd0);
        chk("rst_ferr",     {31'd0, frame_err},  32'd0);
        chk("rst_active",   {31'd0, active},   32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 9600 no parity; settings changed mid-frame must be ignored
        baud_rate = 2'b10; parity_type = 2'b00;
        send_frame(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10);
        rx = 1'b1;
        wait_valid(1);
        repeat (20) @(negedge clk);
        chk("active_after", {31'd0, active}, 32'd0);

        // 19200 even parity, wrong then right parity bit
        baud_rate = 2'b11; parity_type = 2'b10;
        send_frame(8'h07, 2'b11, 2'b10, 1'b0, 1'b1, 2'b11, 2'b10);
        wait_valid(2);
        repeat (20) @(negedge clk);
        send_frame(8'h07, 2'b11, 2'b10, 1'b1, 1'b1, 2'b11, 2'b10);
        wait_valid(3);
        repeat (20) @(negedge clk);

        // 2400 odd parity with a low stop bit, then line held low
        baud_rate = 2'b00; parity_type = 2'b01;
        send_frame(8'h3C, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b01);
        wait_valid(4);
        repeat (3 * bit_clks(2'b00)) @(negedge clk);
        chk("held_low_active", {31'd0, active}, 32'd0);
        chk("held_low_nvalid", n_valid, 32'd4);
        rx = 1'b1;
        repeat (40) @(negedge clk);

        // glitch at 9600: 3 ticks low
        baud_rate = 2'b10; parity_type = 2'b00;
        rx = 1'b0;
        repeat (3 * bit_clks(2'b10) / 16) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bit_clks(2'b10)) @(negedge clk);
        chk("glitch_active", {31'd0, active}, 32'd0);
        chk("glitch_nvalid", n_valid, 32'd4);
        chk("glitch_data",   {24'd0, data_out}, 32'h3C);
        chk("glitch_ferr",   {31'd0, frame_err}, 32'd1);

        // back-to-back at 4800
        baud_rate = 2'b01; parity_type = 2'b00;
        send_frame(8'h55, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00);
        send_frame(8'hFF, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00);
        rx = 1'b1;
        wait_valid(6);
        repeat (20) @(negedge clk);

        // reset during bit 4 at 9600
        baud_rate = 2'b10; parity_type = 2'b00;
        rx = 1'b0;
        repeat (bit_clks(2'b10)) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (bit_clks(2'b10)) @(negedge clk);
        end
        rx = 1'b0;
        repeat (bit_clks(2'b10) / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_active", {31'd0, active}, 32'd0);
        chk("abort_data",   {24'd0, data_out}, 32'd0);
        chk("abort_nvalid", n_valid, 32'd6);
        send_frame(8'h81, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00);
        rx = 1'b1;
        wait_valid(7);
        repeat (20) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port baud_rate  input  2  baud select: 00=2400, 01=4800, 10=9600, 11=19200.
REQ-006 SHALL have port parity_type  input  2  parity select: 01=odd, 10=even, 00/11=no parity bit.
REQ-007 SHALL have port data_out  output  8  last received byte.
REQ-008 SHALL have port valid  output  1  one-clk pulse when a frame completes.
REQ-009 SHALL have port parity_err  output  1  parity mismatch on last frame.
REQ-010 SHALL have port frame_err  output  1  stop bit sampled low on last frame.
REQ-011 SHALL have port active  output  1  high while a frame is being received.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-clk input latency).
REQ-013 Oversample tick SHALL pulse once every DIV clks, DIV = CLK_FREQ/(baud*16), truncated; at 50 MHz: 1302, 651, 325, 162.
REQ-014 Tick counter SHALL restart from 0 on entry to START, so sampling phase aligns to the detected start edge.
REQ-015 baud_rate and parity_type SHALL be latched on entry to START and held constant for the whole frame.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: on synchronized falling edge (prev 1, now 0) SHALL go to START and assert active.
REQ-018 START: at the 8th tick, rx high SHALL return to IDLE (false start, no valid, errors unchanged); rx low SHALL go to DATA.
REQ-019 DATA: SHALL sample one bit every 16 ticks after mid-start, LSB first, 8 bits into a shift register.
REQ-020 After bit 7: parity enabled SHALL go to PARITY; otherwise STOP.
REQ-021 PARITY: sampled bit SHALL be compared against XOR of the 8 data bits (even: equal; odd: inverted); mismatch sets parity_err for this frame.
REQ-022 STOP: bit SHALL be sampled 16 ticks after the previous sample; low sets frame_err for this frame.
REQ-023 One clk after the stop sample: data_out, parity_err, frame_err SHALL update together, valid SHALL pulse for exactly 1 clk, active SHALL drop, FSM SHALL return to IDLE.
REQ-024 Frames with errors SHALL still update data_out and pulse valid.
REQ-025 data_out, parity_err, frame_err SHALL hold until the next valid; parity_err SHALL be 0 when parity disabled.
REQ-026 A falling edge in the same clk that IDLE is re-entered SHALL start a new frame (back-to-back frames, no idle gap required).
REQ-027 Line held low after a frame_err SHALL NOT start a new frame until rx returns high and falls again.
REQ-028 Changes to baud_rate/parity_type mid-frame SHALL have no effect until the next START.

Reset
REQ-029 rst SHALL force: state IDLE, data_out 8'h00, valid 0, parity_err 0, frame_err 0, active 0, counters 0, synchronizer flops 1.
REQ-030 rst asserted mid-frame SHALL abort the frame with no valid pulse; reception resumes on the first falling edge after rst deasserts.

Verification
REQ-031 9600 baud, no parity, send 8'hA5 with 1 stop bit -> valid pulse once, data_out=8'hA5, both errors 0, active high for the frame then low.
REQ-032 19200 baud, even parity, send 8'h07 with parity bit 0 -> data_out=8'h07, parity_err=1; resend with parity bit 1 -> parity_err=0.
REQ-033 2400 baud, odd parity, send 8'h3C with correct parity and stop bit 0 -> valid pulses, data_out=8'h3C, frame_err=1, parity_err=0.
REQ-034 Glitch: rx low for 3 ticks (under half a bit) then high at 9600 -> no valid, active returns 0, outputs unchanged.
REQ-035 Two back-to-back frames 8'h55 then 8'hFF at 4800, no idle gap -> two valid pulses, data_out 8'h55 then 8'hFF.
REQ-036 rst asserted during bit 4 of a frame, released, then 8'h81 sent -> no valid for aborted frame; next valid gives data_out=8'h81.
